// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the SPI / quad-SPI flash bus arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  // WP and HOLD must stay deasserted (high) while the single-bit requester owns the flash.
  localparam logic       WP_IDLE_DRIVE   = 1'b1;
  localparam logic       HOLD_IDLE_DRIVE = 1'b1;
  localparam logic [3:0] A_DQ_OE         = 4'b1101;

  function automatic logic [1:0] owner_of(input arb_state_e st);
    case (st)
      ST_OWN_A: owner_of = OWNER_A;
      ST_OWN_B: owner_of = OWNER_B;
      default:  owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flash_arb_pinmux.sv
// Combinational steering of the flash pins to whichever requester the arbiter state names.
module flash_arb_pinmux
  import flash_arb_pkg::*;
(
  input  arb_state_e state_i,
  input  logic       a_cs_n_i,
  input  logic       a_sck_i,
  input  logic       a_mosi_i,
  input  logic       b_ncs_i,
  input  logic       b_dclk_i,
  input  logic [3:0] b_dataout_i,
  input  logic [3:0] b_dataoe_i,
  input  logic [3:0] flash_dq_in_i,
  output logic       flash_cs_n_o,
  output logic       flash_sck_o,
  output logic [3:0] flash_dq_out_o,
  output logic [3:0] flash_dq_oe_o,
  output logic       a_miso_o,
  output logic [3:0] b_datain_o
);

  always_comb begin
    flash_cs_n_o   = 1'b1;
    flash_sck_o    = 1'b0;
    flash_dq_out_o = 4'b0000;
    flash_dq_oe_o  = 4'b0000;
    a_miso_o       = 1'b0;
    b_datain_o     = 4'b0000;
    case (state_i)
      ST_OWN_A: begin
        flash_cs_n_o   = a_cs_n_i;
        flash_sck_o    = a_sck_i;
        flash_dq_out_o = {HOLD_IDLE_DRIVE, WP_IDLE_DRIVE, 1'b0, a_mosi_i};
        flash_dq_oe_o  = A_DQ_OE;
        a_miso_o       = flash_dq_in_i[1];
      end
      ST_OWN_B: begin
        flash_cs_n_o   = b_ncs_i;
        flash_sck_o    = b_dclk_i;
        flash_dq_out_o = b_dataout_i;
        flash_dq_oe_o  = b_dataoe_i;
        b_datain_o     = flash_dq_in_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Two-requester flash bus arbiter: SPI requester A, quad-SPI requester B, with a
// chip-select-high gap between owners and revocation of an owner that idles while the other waits.
//   state    | meaning
//   ST_IDLE  | no owner, pins parked, next request granted on the following edge
//   ST_OWN_A | requester A drives the flash
//   ST_OWN_B | requester B drives the flash
//   ST_GAP   | pins parked for pGAP_CYCLES cycles before the next grant
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int pGAP_CYCLES = 2,
  parameter int pIDLE_LIMIT = 256
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic       iA_REQ,
  output logic       oA_GNT,
  input  logic       iA_CS_N,
  input  logic       iA_SCK,
  input  logic       iA_MOSI,
  output logic       oA_MISO,
  input  logic       iB_REQ,
  output logic       oB_GNT,
  input  logic       iB_NCS,
  input  logic       iB_DCLK,
  input  logic [3:0] iB_DATAOUT,
  input  logic [3:0] iB_DATAOE,
  output logic [3:0] oB_DATAIN,
  output logic       oFLASH_CS_N,
  output logic       oFLASH_SCK,
  output logic [3:0] oFLASH_DQ_OUT,
  output logic [3:0] oFLASH_DQ_OE,
  input  logic [3:0] iFLASH_DQ_IN,
  output logic [1:0] oOWNER,
  output logic       oVIOL
);

  localparam bit REVOKE_EN = (pIDLE_LIMIT > 0);
  localparam int CNT_W     = REVOKE_EN ? $clog2(pIDLE_LIMIT + 1) : 1;
  localparam int GAP_W     = (pGAP_CYCLES > 1) ? $clog2(pGAP_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(pIDLE_LIMIT);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(pIDLE_LIMIT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(pGAP_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             last_b_q, last_b_d;
  logic             viol_q, viol_d;
  logic             a_cs_n_prev_q, b_ncs_prev_q;

  logic owner_cs_n, other_req, idle_wait, revoke;
  logic a_cs_fall, b_cs_fall;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q       <= ST_IDLE;
      idle_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      last_b_q      <= 1'b1;
      viol_q        <= 1'b0;
      a_cs_n_prev_q <= 1'b1;
      b_ncs_prev_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      last_b_q      <= last_b_d;
      viol_q        <= viol_d;
      a_cs_n_prev_q <= iA_CS_N;
      b_ncs_prev_q  <= iB_NCS;
    end
  end

  always_comb begin
    owner_cs_n = 1'b1;
    other_req  = 1'b0;
    if (state_q == ST_OWN_A) begin
      owner_cs_n = iA_CS_N;
      other_req  = iB_REQ;
    end else if (state_q == ST_OWN_B) begin
      owner_cs_n = iB_NCS;
      other_req  = iA_REQ;
    end
    idle_wait = REVOKE_EN && owner_cs_n && other_req;
    revoke    = idle_wait && (idle_cnt_q == IDLE_LAST);
  end

  // A chip-select falling while its requester does not own the bus is flagged once.
  assign a_cs_fall = a_cs_n_prev_q && !iA_CS_N && (state_q != ST_OWN_A);
  assign b_cs_fall = b_ncs_prev_q  && !iB_NCS  && (state_q != ST_OWN_B);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    gap_cnt_d  = gap_cnt_q;
    last_b_d   = last_b_q;
    viol_d     = a_cs_fall || b_cs_fall;

    case (state_q)
      ST_IDLE: begin
        if (iA_REQ && (!iB_REQ || last_b_q)) begin
          state_d  = ST_OWN_A;
          last_b_d = 1'b0;
        end else if (iB_REQ) begin
          state_d  = ST_OWN_B;
          last_b_d = 1'b1;
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        if (idle_wait) begin
          idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
        if (owner_cs_n && !((state_q == ST_OWN_A) ? iA_REQ : iB_REQ)) begin
          state_d = ST_GAP;
        end else if (revoke) begin
          state_d = ST_GAP;
          viol_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) idle_cnt_d = '0;
    if (state_d == ST_GAP && state_q != ST_GAP) gap_cnt_d = GAP_LOAD;
  end

  assign oA_GNT = (state_q == ST_OWN_A);
  assign oB_GNT = (state_q == ST_OWN_B);
  assign oOWNER = owner_of(state_q);
  assign oVIOL  = viol_q;

  flash_arb_pinmux u_pinmux (
    .state_i        (state_q),
    .a_cs_n_i       (iA_CS_N),
    .a_sck_i        (iA_SCK),
    .a_mosi_i       (iA_MOSI),
    .b_ncs_i        (iB_NCS),
    .b_dclk_i       (iB_DCLK),
    .b_dataout_i    (iB_DATAOUT),
    .b_dataoe_i     (iB_DATAOE),
    .flash_dq_in_i  (iFLASH_DQ_IN),
    .flash_cs_n_o   (oFLASH_CS_N),
    .flash_sck_o    (oFLASH_SCK),
    .flash_dq_out_o (oFLASH_DQ_OUT),
    .flash_dq_oe_o  (oFLASH_DQ_OE),
    .a_miso_o       (oA_MISO),
    .b_datain_o     (oB_DATAIN)
  );

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: pin-mux vector table plus hand-written ownership sequences.
module tb_flash_bus_arbiter;

  logic       iCLK, iRESETn;
  logic       iA_REQ, oA_GNT, iA_CS_N, iA_SCK, iA_MOSI, oA_MISO;
  logic       iB_REQ, oB_GNT, iB_NCS, iB_DCLK;
  logic [3:0] iB_DATAOUT, iB_DATAOE, oB_DATAIN;
  logic       oFLASH_CS_N, oFLASH_SCK;
  logic [3:0] oFLASH_DQ_OUT, oFLASH_DQ_OE, iFLASH_DQ_IN;
  logic [1:0] oOWNER;
  logic       oVIOL;

  int n_cmp = 0;
  int n_bad = 0;

  flash_bus_arbiter #(.pGAP_CYCLES(2), .pIDLE_LIMIT(16)) dut (
    .iCLK(iCLK), .iRESETn(iRESETn),
    .iA_REQ(iA_REQ), .oA_GNT(oA_GNT), .iA_CS_N(iA_CS_N), .iA_SCK(iA_SCK),
    .iA_MOSI(iA_MOSI), .oA_MISO(oA_MISO),
    .iB_REQ(iB_REQ), .oB_GNT(oB_GNT), .iB_NCS(iB_NCS), .iB_DCLK(iB_DCLK),
    .iB_DATAOUT(iB_DATAOUT), .iB_DATAOE(iB_DATAOE), .oB_DATAIN(oB_DATAIN),
    .oFLASH_CS_N(oFLASH_CS_N), .oFLASH_SCK(oFLASH_SCK),
    .oFLASH_DQ_OUT(oFLASH_DQ_OUT), .oFLASH_DQ_OE(oFLASH_DQ_OE),
    .iFLASH_DQ_IN(iFLASH_DQ_IN), .oOWNER(oOWNER), .oVIOL(oVIOL)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic       a_cs_n, a_sck, a_mosi, b_ncs, b_dclk;
    logic [3:0] b_dout, b_doe, fdq;
    logic       e_cs_n, e_sck;
    logic [3:0] e_out, e_oe;
    logic       e_miso;
    logic [3:0] e_bdin;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic park_pins();
    iA_CS_N = 1'b1; iA_SCK = 1'b0; iA_MOSI = 1'b0;
    iB_NCS = 1'b1; iB_DCLK = 1'b0; iB_DATAOUT = 4'h0; iB_DATAOE = 4'h0;
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, " owner"}, 8'(oOWNER), 8'h0);
    chk({tag, " gnt_a"}, 8'(oA_GNT), 8'h0);
    chk({tag, " gnt_b"}, 8'(oB_GNT), 8'h0);
    chk({tag, " cs_n"},  8'(oFLASH_CS_N), 8'h1);
    chk({tag, " sck"},   8'(oFLASH_SCK), 8'h0);
    chk({tag, " dq_oe"}, 8'(oFLASH_DQ_OE), 8'h0);
    chk({tag, " dq_out"}, 8'(oFLASH_DQ_OUT), 8'h0);
    chk({tag, " viol"},  8'(oVIOL), 8'h0);
    chk({tag, " a_miso"}, 8'(oA_MISO), 8'h0);
    chk({tag, " b_datain"}, 8'(oB_DATAIN), 8'h0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    iA_CS_N = v.a_cs_n; iA_SCK = v.a_sck; iA_MOSI = v.a_mosi;
    iB_NCS = v.b_ncs; iB_DCLK = v.b_dclk; iB_DATAOUT = v.b_dout; iB_DATAOE = v.b_doe;
    iFLASH_DQ_IN = v.fdq;
    #1;
    chk($sformatf("vec%0d cs_n", i),   8'(oFLASH_CS_N),   8'(v.e_cs_n));
    chk($sformatf("vec%0d sck", i),    8'(oFLASH_SCK),    8'(v.e_sck));
    chk($sformatf("vec%0d dq_out", i), 8'(oFLASH_DQ_OUT), 8'(v.e_out));
    chk($sformatf("vec%0d dq_oe", i),  8'(oFLASH_DQ_OE),  8'(v.e_oe));
    chk($sformatf("vec%0d a_miso", i), 8'(oA_MISO),       8'(v.e_miso));
    chk($sformatf("vec%0d b_datain", i), 8'(oB_DATAIN),   8'(v.e_bdin));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // A owns for 0..3, B owns for 4..7
    vecs[0] = '{1'b0,1'b1,1'b1,1'b1,1'b1,4'hF,4'hF,4'h2, 1'b0,1'b1,4'hD,4'hD,1'b1,4'h0};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b1,1'b1,4'hA,4'h5,4'hD, 1'b0,1'b0,4'hC,4'hD,1'b0,4'h0};
    vecs[2] = '{1'b1,1'b1,1'b0,1'b1,1'b0,4'h0,4'h0,4'hF, 1'b1,1'b1,4'hC,4'hD,1'b1,4'h0};
    vecs[3] = '{1'b0,1'b1,1'b1,1'b1,1'b1,4'h3,4'h3,4'h0, 1'b0,1'b1,4'hD,4'hD,1'b0,4'h0};
    vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b1,4'hA,4'hF,4'h6, 1'b0,1'b1,4'hA,4'hF,1'b0,4'h6};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,1'b0,4'h5,4'h0,4'h9, 1'b0,1'b0,4'h5,4'h0,1'b0,4'h9};
    vecs[6] = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h3,4'h1,4'hF, 1'b1,1'b1,4'h3,4'h1,1'b0,4'hF};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b0,1'b1,4'hC,4'hC,4'h2, 1'b0,1'b1,4'hC,4'hC,1'b0,4'h2};

    iRESETn = 1'b0; iA_REQ = 1'b0; iB_REQ = 1'b0; iFLASH_DQ_IN = 4'hF;
    park_pins();
    #3;
    chk_parked("reset");
    @(negedge iCLK);
    iRESETn = 1'b1;
    tick();

    // A-only transaction with gap timing
    iA_REQ = 1'b1;
    #1 chk("a_only gnt before edge", 8'(oA_GNT), 8'h0);
    tick();
    chk("a_only gnt", 8'(oA_GNT), 8'h1);
    chk("a_only owner", 8'(oOWNER), 8'h1);
    chk("a_only dq_oe", 8'(oFLASH_DQ_OE), 8'hD);
    iA_CS_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iA_SCK = 1'b1;
      #1 chk("a_only sck high", 8'(oFLASH_SCK), 8'h1);
      chk("a_only cs_n low", 8'(oFLASH_CS_N), 8'h0);
      @(negedge iCLK);
      iA_SCK = 1'b0;
      tick();
    end
    chk("a_only held gnt", 8'(oA_GNT), 8'h1);
    iA_CS_N = 1'b1; iA_REQ = 1'b0;
    tick();
    chk_parked("a_only gap1");
    iA_REQ = 1'b1;
    tick();
    chk("a_only gap2 gnt", 8'(oA_GNT), 8'h0);
    chk("a_only gap2 cs_n", 8'(oFLASH_CS_N), 8'h1);
    tick();
    chk("a_only idle gnt", 8'(oA_GNT), 8'h0);
    tick();
    chk("a_only regrant", 8'(oA_GNT), 8'h1);
    iA_REQ = 1'b0;
    ticks(3);

    // pin-mux tables
    iA_REQ = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) run_vec(i);
    park_pins();
    iA_REQ = 1'b0;
    ticks(3);
    iB_REQ = 1'b1;
    tick();
    chk("tbl b gnt", 8'(oB_GNT), 8'h1);
    for (int i = 4; i < 8; i++) run_vec(i);
    park_pins();
    iB_REQ = 1'b0;
    ticks(3);

    // simultaneous requests out of reset, alternating ties
    iRESETn = 1'b0; iA_REQ = 1'b1; iB_REQ = 1'b1;
    #2;
    @(negedge iCLK);
    iRESETn = 1'b1;
    tick();
    chk("tie1 gnt_a", 8'(oA_GNT), 8'h1);
    chk("tie1 gnt_b", 8'(oB_GNT), 8'h0);
    iA_REQ = 1'b0;
    ticks(3);
    chk("tie1 b idle", 8'(oB_GNT), 8'h0);
    tick();
    chk("tie1 then b", 8'(oB_GNT), 8'h1);
    chk("tie1 owner b", 8'(oOWNER), 8'h2);
    iB_REQ = 1'b0;
    tick();
    iA_REQ = 1'b1; iB_REQ = 1'b1;
    ticks(3);
    chk("tie2 gnt_a", 8'(oA_GNT), 8'h1);
    chk("tie2 gnt_b", 8'(oB_GNT), 8'h0);

    // B keeps the bus past its request drop while NCS is low
    iA_REQ = 1'b0;
    ticks(4);
    chk("hold b gnt", 8'(oB_GNT), 8'h1);
    iB_NCS = 1'b0;
    tick();
    iB_REQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold b while ncs low", 8'(oB_GNT), 8'h1);
    end
    chk("hold b no viol", 8'(oVIOL), 8'h0);
    iB_NCS = 1'b1;
    tick();
    chk("hold b released", 8'(oB_GNT), 8'h0);
    chk("hold b cs_n", 8'(oFLASH_CS_N), 8'h1);
    ticks(2);

    // revocation after 16 idle cycles with B waiting
    iA_REQ = 1'b1;
    tick();
    chk("rev gnt_a", 8'(oA_GNT), 8'h1);
    iB_REQ = 1'b1;
    ticks(15);
    chk("rev viol before limit", 8'(oVIOL), 8'h0);
    chk("rev gnt_a before limit", 8'(oA_GNT), 8'h1);
    tick();
    chk("rev viol pulse", 8'(oVIOL), 8'h1);
    chk("rev gnt_a dropped", 8'(oA_GNT), 8'h0);
    chk("rev owner none", 8'(oOWNER), 8'h0);
    tick();
    chk("rev viol one cycle", 8'(oVIOL), 8'h0);
    tick();
    chk("rev b idle", 8'(oB_GNT), 8'h0);
    tick();
    chk("rev b granted", 8'(oB_GNT), 8'h1);
    iA_REQ = 1'b0; iB_REQ = 1'b0;
    ticks(3);

    // non-owner CS drive, then reset mid-transfer
    iA_REQ = 1'b1;
    tick();
    iB_NCS = 1'b0;
    #1 chk("viol cs follows a", 8'(oFLASH_CS_N), 8'h1);
    tick();
    chk("viol pulse", 8'(oVIOL), 8'h1);
    tick();
    chk("viol single", 8'(oVIOL), 8'h0);
    iA_CS_N = 1'b0;
    #1 chk("xfer cs low", 8'(oFLASH_CS_N), 8'h0);
    #1 iRESETn = 1'b0;
    #1 chk_parked("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
